// File: rtl/part_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : part_add_pipe
// Description : Two-stage pipelined 64-bit partitioned adder. One add per
//               transaction over 8 byte lanes, 4 word lanes, 2 dword lanes or
//               a single qword, selected by mode. Bytes 0-3 are summed in
//               stage 1 and bytes 4-7 in stage 2. Lane flags and optional
//               unsigned saturation are applied in stage 2.
// Ports       : clk, rst_n          clock / async active-low reset
//               in_valid, in_ready  operand handshake
//               mode                00 byte, 01 word, 10 dword, 11 qword
//               a, b                64-bit operands, lane 0 in the low bits
//               out_valid, out_ready result handshake
//               sum                 lane-wise sum, same layout as operands
//               cout                per-byte carry flag, set only on lane tops
//               busy                any stage holds a transaction
// Revision    : 1.0 - initial release
// ============================================================================
module part_add_pipe #(
    parameter int SAT_EN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic [7:0]  cout,
    output logic        busy
);

    // Stage 1 registers
    logic        r_s1_v;
    logic [1:0]  r_s1_mode;
    logic [31:0] r_s1_a_hi;
    logic [31:0] r_s1_b_hi;
    logic [31:0] r_s1_sum_lo;
    logic [3:0]  r_s1_c_lo;
    logic        r_s1_cmid;

    // Stage 2 (output) registers
    logic        r_s2_v;
    logic [63:0] r_sum;
    logic [7:0]  r_cout;

    logic        w_adv2;
    logic        w_in_fire;

    // Lane mask: low byte-index bits that stay inside one lane.
    // A byte links its carry from the byte below when (k & mask) != 0,
    // and tops a lane when (k & mask) == mask.
    logic [2:0]  w_mask1;
    logic [2:0]  w_mask2;

    logic [31:0] w_s1_sum;
    logic [3:0]  w_s1_c;
    logic [31:0] w_s2_sum;
    logic [3:0]  w_s2_c;
    logic [8:0]  w_t1;
    logic [8:0]  w_t2;
    logic        w_cy1;
    logic        w_cy2;

    logic [63:0] w_raw_sum;
    logic [7:0]  w_raw_c;
    logic [63:0] w_fin_sum;
    logic [7:0]  w_fin_cout;

    assign w_adv2    = !r_s2_v || out_ready;
    assign in_ready  = !r_s1_v || w_adv2;
    assign w_in_fire = in_valid && in_ready;

    assign w_mask1 = (3'd1 << mode) - 3'd1;
    assign w_mask2 = (3'd1 << r_s1_mode) - 3'd1;

    // Stage 1: bytes 0-3 as a ripple of 9-bit adds, broken at lane starts.
    always_comb begin
        w_s1_sum = '0;
        w_s1_c   = '0;
        w_t1     = '0;
        w_cy1    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cy1 = ((3'(k) & w_mask1) != 3'd0) ? w_cy1 : 1'b0;
            w_t1  = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]} + {8'd0, w_cy1};
            w_s1_sum[8*k +: 8] = w_t1[7:0];
            w_s1_c[k]          = w_t1[8];
            w_cy1              = w_t1[8];
        end
    end

    // Stage 2: bytes 4-7; byte 4 links to byte 3 only in qword mode, which
    // is the only mode where carry_mid can be nonzero.
    always_comb begin
        w_s2_sum = '0;
        w_s2_c   = '0;
        w_t2     = '0;
        w_cy2    = r_s1_cmid;
        for (int k = 4; k < 8; k++) begin
            w_cy2 = ((3'(k) & w_mask2) != 3'd0) ? w_cy2 : 1'b0;
            w_t2  = {1'b0, r_s1_a_hi[8*(k-4) +: 8]} + {1'b0, r_s1_b_hi[8*(k-4) +: 8]}
                  + {8'd0, w_cy2};
            w_s2_sum[8*(k-4) +: 8] = w_t2[7:0];
            w_s2_c[k-4]            = w_t2[8];
            w_cy2                  = w_t2[8];
        end
    end

    assign w_raw_sum = {w_s2_sum, r_s1_sum_lo};
    assign w_raw_c   = {w_s2_c, r_s1_c_lo};

    // Per-byte finalisation: flag only lane-top carries; when saturating,
    // every byte takes the carry of the top byte of its own lane (k | mask).
    genvar gk;
    generate
        for (gk = 0; gk < 8; gk++) begin : g_byte
            logic w_top;
            logic w_lane_c;
            assign w_top      = ((3'(gk) & w_mask2) == w_mask2);
            assign w_lane_c   = w_raw_c[3'(gk) | w_mask2];
            assign w_fin_cout[gk] = w_top && w_raw_c[gk];
            assign w_fin_sum[8*gk +: 8] = ((SAT_EN != 0) && w_lane_c) ? 8'hFF
                                                                      : w_raw_sum[8*gk +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_mode   <= 2'b00;
            r_s1_a_hi   <= '0;
            r_s1_b_hi   <= '0;
            r_s1_sum_lo <= '0;
            r_s1_c_lo   <= '0;
            r_s1_cmid   <= 1'b0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (w_in_fire) begin
                r_s1_mode   <= mode;
                r_s1_a_hi   <= a[63:32];
                r_s1_b_hi   <= b[63:32];
                r_s1_sum_lo <= w_s1_sum;
                r_s1_c_lo   <= w_s1_c;
                r_s1_cmid   <= (mode == 2'b11) && w_s1_c[3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
            r_sum  <= '0;
            r_cout <= '0;
        end else if (w_adv2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_sum  <= w_fin_sum;
                r_cout <= w_fin_cout;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_s1_v || r_s2_v;

endmodule
`default_nettype wire

// File: tb/tb_part_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_part_add_pipe
// Description : Bench for part_add_pipe. Two instances (wrap and saturating)
//               share one stimulus stream; expectations come from a lane-level
//               arithmetic model and an age-tracked queue of transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_part_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic        in_ready0, out_valid0, busy0;
    logic [63:0] sum0;
    logic [7:0]  cout0;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] sum1;
    logic [7:0]  cout1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] s_wrap;
        logic [63:0] s_sat;
        logic [7:0]  c;
        int          age;
    } item_t;

    item_t q[$];

    always #5 clk = ~clk;

    part_add_pipe #(.SAT_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .cout(cout0), .busy(busy0)
    );

    part_add_pipe #(.SAT_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane arithmetic straight from the definition: split into lanes,
    // add as unsigned integers, carry is bit lw of the lane sum.
    task automatic ref_add(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                           input bit sat, output logic [63:0] s, output logic [7:0] c);
        int lw;
        int lanes;
        logic [63:0] lm;
        logic [64:0] t;
        logic [63:0] lv;
        lw    = 8 << m;
        lanes = 8 >> m;
        lm    = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
        s = '0;
        c = '0;
        for (int i = 0; i < lanes; i++) begin
            t  = {1'b0, (x >> (i*lw)) & lm} + {1'b0, (y >> (i*lw)) & lm};
            lv = t[63:0] & lm;
            if (t[lw]) begin
                c[(i+1)*(lw/8)-1] = 1'b1;
                if (sat) lv = lm;
            end
            s = s | (lv << (i*lw));
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit v, input logic [1:0] m, input logic [63:0] x,
                       input logic [63:0] y, input bit ordy, output bit acc);
        bit    exp_rdy;
        bit    exp_ov;
        bit    drn;
        item_t it;
        in_valid  = v;
        mode      = m;
        a         = x;
        b         = y;
        out_ready = ordy;
        #1;
        // Two transactions in flight means both stages are full.
        exp_rdy = (q.size() < 2) || ordy;
        // The oldest transaction reaches the output one edge after acceptance.
        exp_ov  = (q.size() > 0) && (q[0].age >= 1);
        chk("in_ready0", 64'(in_ready0), 64'(exp_rdy));
        chk("in_ready1", 64'(in_ready1), 64'(exp_rdy));
        chk("out_valid0", 64'(out_valid0), 64'(exp_ov));
        chk("out_valid1", 64'(out_valid1), 64'(exp_ov));
        chk("busy0", 64'(busy0), 64'(q.size() > 0));
        if (exp_ov) begin
            chk("sum_wrap", sum0, q[0].s_wrap);
            chk("cout_wrap", 64'(cout0), 64'(q[0].c));
            chk("sum_sat", sum1, q[0].s_sat);
            chk("cout_sat", 64'(cout1), 64'(q[0].c));
        end
        acc = v && exp_rdy;
        drn = exp_ov && ordy;
        @(posedge clk);
        if (drn) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
            ref_add(m, x, y, 1'b0, it.s_wrap, it.c);
            ref_add(m, x, y, 1'b1, it.s_sat, it.c);
            it.age = 0;
            q.push_back(it);
        end
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ov"}, 64'({out_valid0, out_valid1}), 64'd0);
        chk({tag, "_sum0"}, sum0, 64'd0);
        chk({tag, "_sum1"}, sum1, 64'd0);
        chk({tag, "_cout"}, 64'({cout0, cout1}), 64'd0);
        chk({tag, "_busy"}, 64'({busy0, busy1}), 64'd0);
        chk({tag, "_rdy"}, 64'({in_ready0, in_ready1}), 64'h3);
    endtask

    // Reset is asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        q.delete();
        for (int i = 0; i < n; i++) begin
            check_idle_outputs("reset");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic drain(input string tag);
        bit acc;
        int budget;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            cyc(1'b0, 2'b00, '0, '0, 1'b1, acc);
            budget--;
        end
        chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        bit acc;
        bit seen_stall;
        int sent;
        int budget;
        logic [63:0] ra;
        logic [63:0] rb;

        // Reset then idle
        #1;
        do_reset(3);
        cyc(1'b0, 2'b00, '0, '0, 1'b1, acc);

        // Directed vectors: byte wrap, qword carry across stages, word saturation
        cyc(1'b1, 2'b00, 64'hFF01_7F80_0000_00FF, 64'h0101_0180_0000_0001, 1'b1, acc);
        cyc(1'b1, 2'b11, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, acc);
        cyc(1'b1, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, acc);
        cyc(1'b1, 2'b01, 64'hFFFF_0001_8000_1234, 64'h0001_0001_8000_0001, 1'b1, acc);
        cyc(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1'b1, acc);
        drain("directed");

        // Backpressure: 6 dword ops, consumer stalls cycles 3..6
        sent       = 0;
        seen_stall = 1'b0;
        budget     = 40;
        for (int c = 0; (sent < 6 || q.size() > 0) && budget > 0; c++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (!in_ready0 && sent < 6) seen_stall = 1'b1;
            cyc(sent < 6, 2'b10, ra, rb, !(c >= 3 && c <= 6), acc);
            if (acc) sent++;
            budget--;
        end
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_stall_seen", 64'(seen_stall), 64'd1);
        drain("bp");

        // Randomized traffic with random valid/ready
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ~ra + 64'(($urandom_range(0, 2)));
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ra, rb,
                $urandom_range(0, 3) != 0, acc);
        end
        drain("random");

        // Reset with both stages full
        budget = 10;
        while (q.size() < 2 && budget > 0) begin
            cyc(1'b1, 2'b01, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
            budget--;
        end
        chk("fill_before_reset", 64'(q.size()), 64'd2);
        do_reset(2);
        cyc(1'b0, 2'b00, '0, '0, 1'b1, acc);
        cyc(1'b1, 2'b00, 64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
        cyc(1'b0, 2'b00, '0, '0, 1'b1, acc);
        cyc(1'b0, 2'b00, '0, '0, 1'b1, acc);
        drain("post_reset_op");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
